// File: rtl/fib_gen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fib_gen_pkg : widths, state encoding and range limits for fib_gen
// Revision    : 1.0
// ----------------------------------------------------------------------------
package fib_gen_pkg;

  localparam int W           = 20;
  localparam int N_W         = 5;
  // Largest index whose Fibonacci value fits in W bits.
  localparam int F_MAX_INDEX = 30;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fib_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fib_gen_if : start/ready/done_tick request-result bundle for fib_gen
// Revision   : 1.0
// ----------------------------------------------------------------------------
interface fib_gen_if
  import fib_gen_pkg::*;
();

  logic           start;
  logic [N_W-1:0] n;
  logic           ready;
  logic           done_tick;
  logic [W-1:0]   f;
  logic           overflow;

  modport master (
    output start, n,
    input  ready, done_tick, f, overflow
  );

  modport slave (
    input  start, n,
    output ready, done_tick, f, overflow
  );

endinterface
`default_nettype wire

// File: rtl/fib_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fib_gen  : iterative Fibonacci generator, saturating at the W-bit range
// Revision : 1.0
// ----------------------------------------------------------------------------
module fib_gen
  import fib_gen_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  reset,
  fib_gen_if.slave   bus
);

  logic [1:0]     r_state;
  logic [1:0]     w_state_next;
  logic [W-1:0]   r_t0;
  logic [W-1:0]   r_t1;
  logic [N_W-1:0] r_n_reg;
  logic           r_ovf;
  logic [W-1:0]   r_f;
  logic           r_overflow;

  logic [W:0]     w_sum;
  logic           w_op_last;
  logic [W-1:0]   w_t1_fin;
  logic           w_ovf_fin;

  // Final-iteration detection and the values latched into f/overflow.
  always_comb begin
    w_sum     = {1'b0, r_t1} + {1'b0, r_t0};
    w_op_last = 1'b0;
    w_t1_fin  = r_t1;
    w_ovf_fin = r_ovf;
    if (r_n_reg == '0) begin
      w_op_last = 1'b1;
      w_t1_fin  = '0;
    end else if (r_n_reg == N_W'(1)) begin
      w_op_last = 1'b1;
    end else if (w_sum[W]) begin
      w_op_last = 1'b1;
      w_t1_fin  = '1;
      w_ovf_fin = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = OP;
      OP:      if (w_op_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready     = (r_state == IDLE);
    bus.done_tick = (r_state == DONE);
  end

  // f is loaded on the edge that leaves OP so it is valid throughout done_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_t0       <= '0;
      r_t1       <= '0;
      r_n_reg    <= '0;
      r_ovf      <= 1'b0;
      r_f        <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_n_reg <= bus.n;
            r_t0    <= '0;
            r_t1    <= W'(1);
            r_ovf   <= 1'b0;
          end
        end
        OP: begin
          if (w_op_last) begin
            r_t1       <= w_t1_fin;
            r_ovf      <= w_ovf_fin;
            r_f        <= w_t1_fin;
            r_overflow <= w_ovf_fin;
          end else begin
            r_t1    <= w_sum[W-1:0];
            r_t0    <= r_t1;
            r_n_reg <= r_n_reg - N_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.f        = r_f;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fib_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fib_gen : scoreboard bench for fib_gen against an arithmetic reference
// Revision   : 1.0
// ----------------------------------------------------------------------------
module tb_fib_gen;
  import fib_gen_pkg::*;

  typedef struct {
    int          n;
    int          e0;
    logic [W-1:0] f;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  fib_gen_if bus ();

  fib_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: plain Fibonacci recurrence, saturated to the W-bit range.
  function automatic exp_t model(input int nn, input int e0);
    exp_t   e;
    longint a = 0;
    longint b = 1;
    longint t;
    longint lim = (longint'(1) << W) - 1;
    for (int i = 0; i < nn; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    e.n  = nn;
    e.e0 = e0;
    if (a > lim) begin
      e.f   = '1;
      e.ovf = 1'b1;
    end else begin
      e.f   = W'(a);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.done_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   lat;
        int   bound;
        e     = sb.pop_front();
        lat   = cyc - e.e0;
        bound = (e.n < 1) ? 1 : e.n;
        check($sformatf("f[n=%0d]", e.n), 32'(bus.f), 32'(e.f));
        check($sformatf("ovf[n=%0d]", e.n), 32'(bus.overflow), 32'(e.ovf));
        check($sformatf("ready_in_done[n=%0d]", e.n), 32'(bus.ready), 32'd0);
        if (e.ovf)
          check($sformatf("lat_bound[n=%0d]", e.n), 32'(lat >= 1 && lat <= bound), 32'd1);
        else
          check($sformatf("latency[n=%0d]", e.n), 32'(lat), 32'(bound));
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ready && k < 200);
    if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge; the following posedge is the accepting edge E0.
  task automatic issue(input int nn);
    if (!bus.ready) wait_idle();
    bus.start = 1'b1;
    bus.n     = N_W'(nn);
    sb.push_back(model(nn, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int e0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.n     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done_tick), 32'd0);
    check("rst_f", 32'(bus.f), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(0);  wait_idle();
    issue(1);  wait_idle();
    issue(10); wait_idle();
    repeat (5) @(negedge clk);
    check("hold_f", 32'(bus.f), 32'd55);
    check("hold_done", 32'(bus.done_tick), 32'd0);
    issue(F_MAX_INDEX); wait_idle();
    issue(31); wait_idle();

    // A start pulse mid-OP with a new n must be ignored.
    issue(20);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.n     = N_W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check("after_ignored_f", 32'(bus.f), 32'd6765);

    // Reset mid-run aborts without any done_tick.
    bus.start = 1'b1;
    bus.n     = N_W'(25);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_f", 32'(bus.f), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_idle", 32'(bus.ready), 32'd1);

    // start held high: back-to-back runs every 9 cycles.
    bus.start = 1'b1;
    bus.n     = N_W'(7);
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) sb.push_back(model(7, e0 + 9 * k));
    while (cyc != e0 + 25) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      issue(int'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    repeat (5) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fib_gen.md
Name: fib_gen

Overview:
- Iterative Fibonacci generator. Computes F(n) for a 5-bit index n, with F(0)=0 and F(1)=1.
- Sits directly upstream of the 20-bit binary-to-6-digit BCD converter:
  - done_tick drives the converter's start input.
  - f drives the converter's bin input.
- Start/ready/done_tick handshake, matching the downstream stage.
- Saturates and flags overflow when F(n) exceeds the 20-bit range.

Parameters:
- W, 20, result width in bits. Must equal the BCD converter's bin width.
- N_W, 5, index width in bits. Maximum index is 2^N_W-1 = 31.

Ports:
- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a computation; sampled only while ready=1
- n  in  N_W  requested index; latched on the accepted start edge
- ready  out  1  high in IDLE only
- done_tick  out  1  one-cycle pulse, high in DONE only
- f  out  W  result; registered and held until the next DONE
- overflow  out  1  result saturated; registered and held with f

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - f=0, overflow=0. ready=1 and done_tick=0 follow from state.
  - Internal t0, t1, n_reg and ovf are cleared.
  - Reset mid-operation aborts the computation immediately. f and overflow are cleared, not preserved.
- States: IDLE, OP, DONE. 2-bit encoding.
  - ready = (state==IDLE)
  - done_tick = (state==DONE)
- IDLE:
  - Sampling start=1 at an edge (E0) does the following: n_reg<=n, t0<=0, t1<=1, ovf<=0, state<=OP.
  - start=0 means stay in IDLE.
  - n is not sampled on any other edge.
- OP, evaluated each edge:
  - n_reg==0: t1<=0, then DONE.
  - n_reg==1: go to DONE.
  - Otherwise, compute sum = {1'b0,t1}+{1'b0,t0}, W+1 bits wide.
    - If sum[W]=1: ovf<=1, t1<=all ones, go to DONE immediately.
    - Else: t1<=sum[W-1:0], t0<=t1, n_reg<=n_reg-1, stay in OP.
- Entry into DONE: on the same edge that leaves OP, f<=final t1 and overflow<=final ovf.
  - This makes f valid during the whole done_tick cycle.
  - Required because the downstream converter samples bin on the start cycle.
- DONE: one cycle, then unconditional return to IDLE. f and overflow hold.
- Latency:
  - The OP phase lasts max(n,1) cycles.
  - done_tick is high in the cycle after edge E0+max(n,1).
  - Overflow cases finish at or before this bound.
- start while in OP or DONE is ignored; no queuing.
- start held high continuously gives back-to-back runs: accepted on the first IDLE edge after each DONE.
- Range: F(30)=832040 is the largest value that fits in W=20. n=31 must saturate (F(31)=1346269).
- Arithmetic is unsigned. No wrap-around is ever visible on f.

Decomposition:
- Shared package holds:
  - W, N_W.
  - State localparams IDLE=0, OP=1, DONE=2.
  - F_MAX_INDEX=30 (largest non-saturating index for W=20), for benches.
- No sub-module: the datapath is one adder, a compare and a down-counter.
- A top-level wrapper instantiates fib_gen and the BCD converter. It is not part of this block.

Test Plan:
- Reset, then n=0, start one cycle → done_tick in cycle E0+1; f=0, overflow=0; ready returns next cycle.
- n=1 → done_tick in cycle E0+1; f=1, overflow=0.
- n=10 → done_tick exactly once, in cycle E0+10; f=55. f holds 55 while idle with start=0.
- n=30 → f=832040 (0xCB228), overflow=0. Then n=31 → f=0xFFFFF, overflow=1, done_tick by cycle E0+31.
- n=20 started, n changed to 5 and start pulsed mid-OP → ignored; f=6765.
  - Then assert reset mid-run of n=25 → ready=1, f=0 immediately, no done_tick.
- start held high with n=7 → repeated done_tick pulses every 9 cycles, f=13 each time.
  - Chained to the BCD converter, this gives bcd1=1, bcd0=3, others 0.
